uncache_axi_bridge: RTL
=======================

// Module: uncache_axi_bridge
// PURPOSE
//  Responder for the uncached data-memory request interface driven by the memory-stage decoder.
//  Accepts one uncached load/store: valid, op, tag/index/offset, pre-shifted wdata, wstrb, size.
//  Runs a single-beat AXI read or write, then returns load data aligned and sign/zero-extended.
//  Sits between the memory stage and the AXI crossbar, parallel to the dcache.
// PARAMETERS
//  ADDR_W    32  physical address width ({tag,index,offset} = 20+8+4)
//  DATA_W    32  data bus width; only 32 is supported
// PORTS
//  clk            in   1   core clock
//  rst            in   1   asynchronous, active-high reset
//  uncache_valid  in   1   request valid
//  uncache_op     in   1   1 = store, 0 = load
//  uncache_tag    in   20  address [31:12]
//  uncache_index  in   8   address [11:4]
//  uncache_offset in   4   address [3:0]
//  uncache_wstrb  in   4   byte enables, already lane-shifted
//  uncache_wdata  in   32  store data, already lane-shifted
//  awsize_in      in   3   AXI store size (0 = byte, 1 = half, 2 = word)
//  arsize_in      in   3   AXI load size
//  load_len       in   2   00 = byte, 01 = half, 11 = word
//  load_sign      in   1   1 = sign-extend, 0 = zero-extend
//  uncache_addr_ok out  1   request accepted this cycle
//  uncache_data_ok out  1   one-cycle completion pulse (load data or store response)
//  uncache_rdata  out  32  aligned and extended load data; valid while data_ok = 1
//  araddr/arsize/arvalid  out 32/3/1;  arready  in  1
//  rdata/rvalid   in   32/1;  rready  out  1
//  awaddr/awsize/awvalid  out 32/3/1;  awready  in  1
//  wdata/wstrb/wvalid     out 32/4/1;  wready   in  1
//  bvalid         in   1;  bready  out  1
// BEHAVIOUR
//  Reset: state = IDLE; every valid/ready output, addr_ok and data_ok = 0; rdata and addresses = 0.
//  addr_ok = uncache_valid & (state == IDLE); combinational, no other state asserts it.
//  On accept, register addr, op, wstrb, wdata, sizes, load_len and load_sign; inputs are then don't-care.
//  addr = {tag, index, offset}; araddr/awaddr carry the full byte address.
//  FSM:
//   IDLE    -> RD_ADDR on a load accept; -> WR_REQ on a store accept.
//   RD_ADDR arvalid = 1 until arready. Then -> RD_DATA.
//   RD_DATA rready = 1. On rvalid, capture the extended data into uncache_rdata. Then -> RESP.
//   WR_REQ  awvalid and wvalid rise together; each drops independently on its own ready.
//           aw_done and w_done flags record completion. When both are set (same-cycle allowed) -> WR_RESP.
//   WR_RESP bready = 1. On bvalid -> RESP.
//   RESP    data_ok = 1 for exactly one cycle. Then -> IDLE. The next accept is possible the cycle after RESP.
//  Latency, zero-wait slave:
//   load: accept(T) -> arvalid T+1 -> rvalid T+2 -> data_ok T+3.
//   store: data_ok at T+3.
//  Load alignment: sh = rdata >> (8*addr[1:0]).
//   byte: ext(sh[7:0]); half: ext(sh[15:0]); word: rdata unchanged.
//   Misaligned loads are filtered upstream; the behaviour for them is undefined.
//  uncache_rdata holds its value until the next load capture.
//  An accepted request always completes; there is no flush/abort input.
//  Outstanding requests: at most one.
//  AXI stability: valid, address and data stay stable while valid & ~ready.
//  Reset mid-transaction: immediate return to IDLE with all valids low.
//   The system resets the slave at the same time.
//  Ignored responses: rresp and bresp are not checked. Fixed fields (len = 0, burst = INCR, id = 0) are tied off at top level.
// STRUCTURE
//  Shared package: FSM state encoding (IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RESP).
//  Shared package: load_len codes (LEN_B = 2'b00, LEN_H = 2'b01, LEN_W = 2'b11).
//  Shared package: AXI size codes.
//  Sub-module load_align_ext: combinational (rdata, off[1:0], len, sign) -> 32-bit result; reused by the dcache path.
// TESTING
//  1 Load byte, signed: addr 0x1FD0_0003, rdata 0x80FF_FFFF
//    -> araddr 0x1FD0_0003, arsize 0, uncache_rdata 0xFFFF_FF80, data_ok at T+3.
//  2 Load half, unsigned: offset 2, rdata 0xBEEF_1234 -> uncache_rdata 0x0000_BEEF.
//  3 Store word: wdata 0xDEAD_BEEF, wstrb 4'hF, awready 3 cycles after wready
//    -> aw/w held stable; a single data_ok after bvalid.
//  4 Back-pressure: arready low 5 cycles, rvalid 4 cycles later
//    -> arvalid and araddr stable; addr_ok stays 0 for a second request until the cycle after data_ok.
//  5 Same-cycle awready and wready, then bvalid the next cycle -> WR_REQ lasts one cycle; data_ok one cycle after bvalid.
//  6 rst asserted during RD_DATA -> all outputs 0 asynchronously; a new load after release completes normally.

Source files
------------

// File: rtl/uncache_axi_bridge_pkg.sv
// Shared definitions for the uncached AXI bridge: FSM encoding, load length codes,
// AXI size/burst codes and bus widths.
package uncache_axi_bridge_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned AXI_ID_W = 4;

  // load_len codes from the memory-stage decoder
  localparam logic [1:0] LEN_B = 2'b00;
  localparam logic [1:0] LEN_H = 2'b01;
  localparam logic [1:0] LEN_W = 2'b11;

  // AXI AxSIZE codes
  localparam logic [2:0] SIZE_B = 3'd0;
  localparam logic [2:0] SIZE_H = 3'd1;
  localparam logic [2:0] SIZE_W = 3'd2;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  typedef enum logic [2:0] {
    StIdle,
    StRdAddr,
    StRdData,
    StWrReq,
    StWrResp,
    StResp
  } state_e;

endpackage

// File: rtl/uncache_axi_bridge_if.sv
// Uncached request port plus the single-beat AXI master port of the bridge.
// master: the bridge itself; slave: the memory stage and AXI slave around it.
interface uncache_axi_bridge_if;
  import uncache_axi_bridge_pkg::*;

  // Memory-stage request side
  logic                uncache_valid;
  logic                uncache_op;
  logic [19:0]         uncache_tag;
  logic [7:0]          uncache_index;
  logic [3:0]          uncache_offset;
  logic [STRB_W-1:0]   uncache_wstrb;
  logic [DATA_W-1:0]   uncache_wdata;
  logic [2:0]          awsize_in;
  logic [2:0]          arsize_in;
  logic [1:0]          load_len;
  logic                load_sign;
  logic                addr_ok;
  logic                data_ok;
  logic [DATA_W-1:0]   uncache_rdata;

  // AXI read address / data
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arsize;
  logic [7:0]          arlen;
  logic [1:0]          arburst;
  logic [AXI_ID_W-1:0] arid;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic                rvalid;
  logic                rready;

  // AXI write address / data / response
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awsize;
  logic [7:0]          awlen;
  logic [1:0]          awburst;
  logic [AXI_ID_W-1:0] awid;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [STRB_W-1:0]   wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  logic                bvalid;
  logic                bready;

  modport master (
    input  uncache_valid, uncache_op, uncache_tag, uncache_index, uncache_offset,
    input  uncache_wstrb, uncache_wdata, awsize_in, arsize_in, load_len, load_sign,
    output addr_ok, data_ok, uncache_rdata,
    output araddr, arsize, arlen, arburst, arid, arvalid,
    input  arready, rdata, rvalid,
    output rready,
    output awaddr, awsize, awlen, awburst, awid, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready, bvalid,
    output bready
  );

  modport slave (
    output uncache_valid, uncache_op, uncache_tag, uncache_index, uncache_offset,
    output uncache_wstrb, uncache_wdata, awsize_in, arsize_in, load_len, load_sign,
    input  addr_ok, data_ok, uncache_rdata,
    input  araddr, arsize, arlen, arburst, arid, arvalid,
    output arready, rdata, rvalid,
    input  rready,
    input  awaddr, awsize, awlen, awburst, awid, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready, bvalid,
    input  bready
  );

endinterface

// File: rtl/uncache_axi_bridge_load_align_ext.sv
// Load data alignment: shifts the addressed lane down to bit 0 and sign/zero-extends
// byte and half loads. Purely combinational; shared with the dcache load path.
module uncache_axi_bridge_load_align_ext
  import uncache_axi_bridge_pkg::*;
(
  input  logic [DATA_W-1:0] rdata_i,
  input  logic [1:0]        off_i,
  input  logic [1:0]        len_i,
  input  logic              sign_i,
  output logic [DATA_W-1:0] result_o
);

  logic [DATA_W-1:0] sh;

  // Lane shift then extend according to the access length
  always_comb begin
    sh = rdata_i >> {off_i, 3'b000};
    case (len_i)
      LEN_B:   result_o = {{24{sign_i & sh[7]}}, sh[7:0]};
      LEN_H:   result_o = {{16{sign_i & sh[15]}}, sh[15:0]};
      default: result_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/uncache_axi_bridge.sv
// Uncached load/store responder: accepts one request from the memory stage, runs a
// single-beat AXI read or write, and returns aligned/extended load data with data_ok.
module uncache_axi_bridge
  import uncache_axi_bridge_pkg::*;
(
  input logic                 clk,
  input logic                 rst,
  uncache_axi_bridge_if.master bus
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   wstrb_q;
  logic [2:0]          awsize_q;
  logic [2:0]          arsize_q;
  logic [1:0]          len_q;
  logic                sign_q;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;
  logic [DATA_W-1:0]   rdata_q;
  logic [DATA_W-1:0]   load_ext;
  logic                accept;
  logic                aw_fire;
  logic                w_fire;

  assign accept  = bus.uncache_valid && (state_q == StIdle);
  assign aw_fire = bus.awvalid && bus.awready;
  assign w_fire  = bus.wvalid && bus.wready;

  // Request side
  assign bus.addr_ok       = accept;
  assign bus.data_ok       = (state_q == StResp);
  assign bus.uncache_rdata = rdata_q;

  // AXI read channel; address and size come straight from the captured request so they
  // cannot change while valid is waiting for ready
  assign bus.araddr  = addr_q;
  assign bus.arsize  = arsize_q;
  assign bus.arlen   = 8'd0;
  assign bus.arburst = AXI_BURST_INCR;
  assign bus.arid    = '0;
  assign bus.arvalid = (state_q == StRdAddr);
  assign bus.rready  = (state_q == StRdData);

  // AXI write channels; aw and w drop independently once their own handshake is done
  assign bus.awaddr  = addr_q;
  assign bus.awsize  = awsize_q;
  assign bus.awlen   = 8'd0;
  assign bus.awburst = AXI_BURST_INCR;
  assign bus.awid    = '0;
  assign bus.awvalid = (state_q == StWrReq) && !aw_done_q;
  assign bus.wdata   = wdata_q;
  assign bus.wstrb   = wstrb_q;
  assign bus.wlast   = 1'b1;
  assign bus.wvalid  = (state_q == StWrReq) && !w_done_q;
  assign bus.bready  = (state_q == StWrResp);

  uncache_axi_bridge_load_align_ext u_align (
    .rdata_i  (bus.rdata),
    .off_i    (addr_q[1:0]),
    .len_i    (len_q),
    .sign_i   (sign_q),
    .result_o (load_ext)
  );

  // Next-state logic and write-channel completion tracking
  always_comb begin
    state_d   = state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d   = bus.uncache_op ? StWrReq : StRdAddr;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      StRdAddr: begin
        if (bus.arready) state_d = StRdData;
      end
      StRdData: begin
        if (bus.rvalid) state_d = StResp;
      end
      StWrReq: begin
        aw_done_d = aw_done_q | aw_fire;
        w_done_d  = w_done_q | w_fire;
        // Both handshakes may complete in the same cycle
        if (aw_done_d && w_done_d) state_d = StWrResp;
      end
      StWrResp: begin
        if (bus.bvalid) state_d = StResp;
      end
      StResp: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and completion flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // Capture the request on accept; inputs are don't-care afterwards
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      awsize_q <= '0;
      arsize_q <= '0;
      len_q    <= LEN_B;
      sign_q   <= 1'b0;
    end else if (accept) begin
      addr_q   <= {bus.uncache_tag, bus.uncache_index, bus.uncache_offset};
      wdata_q  <= bus.uncache_wdata;
      wstrb_q  <= bus.uncache_wstrb;
      awsize_q <= bus.awsize_in;
      arsize_q <= bus.arsize_in;
      len_q    <= bus.load_len;
      sign_q   <= bus.load_sign;
    end
  end

  // Load result register, held until the next read beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else if ((state_q == StRdData) && bus.rvalid) begin
      rdata_q <= load_ext;
    end
  end

endmodule
